// File: rtl/bitscan_encoder_8x3.sv
// bitscan_encoder_8x3: streams the 3-bit index of each set bit of an 8-bit vector, one per handshake beat
module bitscan_encoder_8x3 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out,
  output logic       out_last,
  output logic       zero
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t     state;
  logic [7:0] pending;
  logic [2:0] idx;
  logic       single;
  // later iterations win, so walk toward the bit that must be emitted first
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (pending[MSB_FIRST ? i : 7 - i]) idx = 3'(MSB_FIRST ? i : 7 - i);
  end
  assign single    = (pending & (pending - 8'd1)) == 8'd0;
  assign in_ready  = state == IDLE;
  assign out_valid = state == EMIT;
  assign out       = out_valid ? idx : '0;
  assign out_last  = out_valid && single;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      zero    <= 1'b0;
    end else begin
      zero <= in_ready && in_valid && in == '0;
      if (state == IDLE) begin
        if (in_valid && in != '0) begin
          pending <= in;
          state   <= EMIT;
        end
      end else if (out_ready) begin
        pending <= out_last ? '0 : pending & ~(8'd1 << idx);
        state   <= out_last ? IDLE : EMIT;
      end
    end
  end
endmodule

// File: tb/tb_bitscan_encoder_8x3.sv
// tb_bitscan_encoder_8x3: directed vector table plus random traffic against a queue-based model, both scan orders
module tb_bitscan_encoder_8x3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = '0;
  logic       out_ready = 1'b0;
  logic       rdy0, vld0, last0, zero0;
  logic       rdy1, vld1, last1, zero1;
  logic [2:0] out0, out1;
  int         n_total = 0;
  int         n_pass = 0;
  int         q0[$];
  int         q1[$];
  bit         mz = 1'b0;

  typedef struct {
    bit       rst, iv, ordy;
    bit [7:0] d;
    bit       rdy, vld;
    bit [2:0] o0;
    bit       l0;
    bit [2:0] o1;
    bit       l1;
    bit       z;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  bitscan_encoder_8x3 #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in(in_vec),
    .out_valid(vld0), .out_ready(out_ready), .out(out0), .out_last(last0), .zero(zero0)
  );
  bitscan_encoder_8x3 #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in(in_vec),
    .out_valid(vld1), .out_ready(out_ready), .out(out1), .out_last(last1), .zero(zero1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input bit r, input bit iv, input bit [7:0] d, input bit ordy, input bit rdy,
                     input bit vld, input bit [2:0] o0, input bit l0, input bit [2:0] o1,
                     input bit l1, input bit z);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.rdy = rdy; v.vld = vld;
    v.o0 = o0; v.l0 = l0; v.o1 = o1; v.l1 = l1; v.z = z;
    tv.push_back(v);
  endtask

  // reference: each accepted vector becomes a queue of indices in scan order
  task automatic model_edge(input bit r, input bit iv, input bit [7:0] d, input bit ordy);
    if (r) begin
      q0.delete(); q1.delete(); mz = 1'b0;
    end else if (q0.size() == 0) begin
      mz = iv && d == 8'd0;
      if (iv)
        for (int i = 0; i < 8; i++)
          if (d[i]) begin q0.push_back(i); q1.push_front(i); end
    end else begin
      mz = 1'b0;
      if (ordy) begin void'(q0.pop_front()); void'(q1.pop_front()); end
    end
  endtask

  task automatic check_model();
    bit busy = q0.size() != 0;
    chk("m_ready0", {7'd0, rdy0}, {7'd0, !busy});
    chk("m_ready1", {7'd0, rdy1}, {7'd0, !busy});
    chk("m_valid0", {7'd0, vld0}, {7'd0, busy});
    chk("m_valid1", {7'd0, vld1}, {7'd0, busy});
    chk("m_out0", {5'd0, out0}, busy ? 8'(q0[0]) : 8'd0);
    chk("m_out1", {5'd0, out1}, busy ? 8'(q1[0]) : 8'd0);
    chk("m_last0", {7'd0, last0}, {7'd0, q0.size() == 1});
    chk("m_last1", {7'd0, last1}, {7'd0, q1.size() == 1});
    chk("m_zero0", {7'd0, zero0}, {7'd0, mz});
    chk("m_zero1", {7'd0, zero1}, {7'd0, mz});
  endtask

  task automatic cycle(input bit r, input bit iv, input bit [7:0] d, input bit ordy);
    rst = r; in_valid = iv; in_vec = d; out_ready = ordy;
    @(posedge clk);
    model_edge(r, iv, d, ordy);
    #1;
  endtask

  initial begin
    // reset with live inputs
    add(1, 1, 8'hA5, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h3C, 0, 1, 0, 0, 0, 0, 0, 0);
    // 0xA4: LSB order 2,5,7 / MSB order 7,5,2
    add(0, 1, 8'hA4, 1, 0, 1, 2, 0, 7, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 5, 0, 5, 0, 0);
    add(0, 1, 8'h00, 1, 0, 1, 7, 1, 2, 1, 0);
    add(0, 1, 8'hFF, 1, 1, 0, 0, 0, 0, 0, 0);
    // 0x81 under three stall cycles
    add(0, 1, 8'h81, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0, 1, 8'h42, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 7, 1, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // zero vector then 0x08; zero inputs during EMIT must not pulse
    add(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 8'h08, 1, 0, 1, 3, 1, 3, 1, 0);
    add(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // 0xFF: eight beats each way
    add(0, 1, 8'hFF, 1, 0, 1, 0, 0, 7, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 0, 8'h00, 1, 0, 1, 3'(i), i == 7, 3'(7 - i), i == 7, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    // reset mid-vector, then 0x10
    add(0, 1, 8'h0F, 1, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 8'h10, 1, 0, 1, 4, 1, 4, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    foreach (tv[k]) begin
      cycle(tv[k].rst, tv[k].iv, tv[k].d, tv[k].ordy);
      chk($sformatf("t%0d_ready", k), {6'd0, rdy1, rdy0}, {6'd0, tv[k].rdy, tv[k].rdy});
      chk($sformatf("t%0d_valid", k), {6'd0, vld1, vld0}, {6'd0, tv[k].vld, tv[k].vld});
      chk($sformatf("t%0d_out0", k), {5'd0, out0}, {5'd0, tv[k].o0});
      chk($sformatf("t%0d_last0", k), {7'd0, last0}, {7'd0, tv[k].l0});
      chk($sformatf("t%0d_out1", k), {5'd0, out1}, {5'd0, tv[k].o1});
      chk($sformatf("t%0d_last1", k), {7'd0, last1}, {7'd0, tv[k].l1});
      chk($sformatf("t%0d_zero", k), {6'd0, zero1, zero0}, {6'd0, tv[k].z, tv[k].z});
      check_model();
    end
    for (int n = 0; n < 1500; n++) begin
      bit [7:0] d = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
      check_model();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
